ram_word_arbiter: RTL and testbench

// - Shares the dual-read-port, single-write-port byte RAM (1 KiB, 8-bit, 1-cycle registered reads) between two 32-bit word masters.
// - Arbitrates requests, then sequences each word access as byte operations: reads use both RAM read ports, writes go one enabled byte lane per cycle.
// - Sits between the core's data-side masters (m0 = CPU data, m1 = debug/DMA) and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_word_arbiter_if.sv | 25 ++
 rtl/ram_arb_rr.sv | 35 +++
 rtl/ram_word_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_word_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the word-to-byte RAM arbiter.
package ram_arb_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int NUM_MASTERS = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    RD_C,
    WR
  } state_t;

  // Index of the lowest set lane in a byte-enable mask (0 when the mask is empty).
  function automatic logic [1:0] lowest_lane(input logic [WORD_BYTES-1:0] mask);
    lowest_lane = 2'd0;
    for (int k = WORD_BYTES - 1; k >= 0; k--) begin
      if (mask[k]) lowest_lane = 2'(k);
    end
  endfunction

endpackage

// File: rtl/ram_word_arbiter_if.sv
// Word-master bus shared by the two masters and the arbiter.
interface ram_word_arbiter_if #(
  parameter int AW = 10
);

  logic [1:0]    i_req;
  logic [1:0]    i_we;
  logic [AW-1:0] i_addr  [2];
  logic [31:0]   i_wdata [2];
  logic [3:0]    i_be    [2];
  logic [1:0]    o_gnt;
  logic [1:0]    o_done;
  logic [31:0]   o_rdata;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_be,
    input  o_gnt, o_done, o_rdata
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_be,
    output o_gnt, o_done, o_rdata
  );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: on contention the master not served last wins.
module ram_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // 1 = m1 was served last, so m0 wins the first contention after reset.
  logic last_q;

  // Pick the winner among the active requests.
  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who was served on every accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      // NOTE: non-blocking assignment for all clocked state avoids simulation races.
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_word_arbiter.sv
// Shares a byte RAM (two read ports, one write port, 1-cycle reads) between
// two 32-bit word masters. Reads fetch two bytes per cycle; writes issue one
// enabled byte lane per cycle.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins);
// default build uses the round-robin picker.
module ram_word_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_word_arbiter_if.slave bus,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_waddr,
  output logic [7:0]    o_ram_wdata,
  output logic [AW-1:0] o_ram_raddr,
  output logic [AW-1:0] o_ram_raddr2,
  input  logic [7:0]    i_ram_rdata,
  input  logic [7:0]    i_ram_rdata2
);

  state_t                state_q;
  logic                  cur_q;
  logic [AW-1:0]         base_q;
  logic [31:0]           wdata_q;
  logic [WORD_BYTES-1:0] mask_q;
  logic [15:0]           lo_q;

  logic [1:0]            gnt_vec;
  logic                  accept;
  logic                  win;

  logic [WORD_BYTES-1:0] sel_mask;
  logic [31:0]           sel_data;
  logic [AW-1:0]         sel_base;
  logic [1:0]            lane;

  assign accept    = (state_q == IDLE) && (|bus.i_req);
  assign win       = gnt_vec[1];
  assign bus.o_gnt = accept ? gnt_vec : 2'b00;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign gnt_vec = bus.i_req[0] ? 2'b01 : {bus.i_req[1], 1'b0};
`else
  ram_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.i_req),
    .accept (accept),
    .gnt    (gnt_vec)
  );
`endif

  // Lane source: the incoming request while idle, the latched request in WR,
  // so the first byte write is scheduled on the grant edge itself.
  always_comb begin
    sel_mask = mask_q;
    sel_data = wdata_q;
    sel_base = base_q;
    if (state_q == IDLE) begin
      sel_mask = bus.i_be[win];
      sel_data = bus.i_wdata[win];
      sel_base = bus.i_addr[win] & ~AW'(3);
    end
    lane = lowest_lane(sel_mask);
  end

  // Arbiter FSM with registered RAM-side and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q        <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      lo_q         <= '0;
      bus.o_done   <= '0;
      bus.o_rdata  <= '0;
      o_ram_we     <= 1'b0;
      o_ram_waddr  <= '0;
      o_ram_wdata  <= '0;
      o_ram_raddr  <= '0;
      o_ram_raddr2 <= '0;
    end else begin
      bus.o_done <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cur_q   <= win;
            base_q  <= sel_base;
            wdata_q <= sel_data;
            if (bus.i_we[win]) begin
              state_q     <= WR;
              o_ram_we    <= |sel_mask;
              o_ram_waddr <= sel_base + AW'(lane);
              o_ram_wdata <= sel_data[8*lane +: 8];
              mask_q      <= sel_mask & ~(WORD_BYTES'(1) << lane);
            end else begin
              state_q      <= RD_A;
              o_ram_raddr  <= sel_base;
              o_ram_raddr2 <= sel_base + AW'(1);
            end
          end
        end
        RD_A: begin
          o_ram_raddr  <= base_q + AW'(2);
          o_ram_raddr2 <= base_q + AW'(3);
          state_q      <= RD_B;
        end
        RD_B: begin
          lo_q    <= {i_ram_rdata2, i_ram_rdata};
          state_q <= RD_C;
        end
        RD_C: begin
          bus.o_rdata       <= {i_ram_rdata2, i_ram_rdata, lo_q};
          bus.o_done[cur_q] <= 1'b1;
          state_q           <= IDLE;
        end
        WR: begin
          if (|sel_mask) begin
            o_ram_we    <= 1'b1;
            o_ram_waddr <= sel_base + AW'(lane);
            o_ram_wdata <= sel_data[8*lane +: 8];
            mask_q      <= sel_mask & ~(WORD_BYTES'(1) << lane);
          end else begin
            o_ram_we          <= 1'b0;
            bus.o_done[cur_q] <= 1'b1;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_arbiter.sv
// Self-checking bench for ram_word_arbiter: directed cases plus randomized
// single-master traffic checked against a byte-array memory model.
module tb_ram_word_arbiter;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_word_arbiter_if #(.AW(AW)) bus ();

  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr, ram_raddr2;
  logic [7:0]    ram_wdata, ram_rdata, ram_rdata2;

  ram_word_arbiter #(.AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_ram_we     (ram_we),
    .o_ram_waddr  (ram_waddr),
    .o_ram_wdata  (ram_wdata),
    .o_ram_raddr  (ram_raddr),
    .o_ram_raddr2 (ram_raddr2),
    .i_ram_rdata  (ram_rdata),
    .i_ram_rdata2 (ram_rdata2)
  );

  logic [7:0]    mem     [1024];
  logic [7:0]    ref_mem [1024];
  int            cyc = 0;
  int            wr_count = 0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;
  int            total = 0;
  int            bad = 0;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 7 + 3) ^ (i >> 3));
  endfunction

  // RAM model: registered reads on both ports, one write port; tb preload port.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
    ram_rdata  = '0;
    ram_rdata2 = '0;
    forever begin
      @(posedge clk);
      cyc        <= cyc + 1;
      ram_rdata  <= mem[ram_raddr];
      ram_rdata2 <= mem[ram_raddr2];
      if (ram_we) begin
        mem[ram_waddr] <= ram_wdata;
        wr_count       <= wr_count + 1;
      end else if (pre_we) begin
        mem[pre_addr] <= pre_data;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] word_base(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = word_base(a);
    return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = word_base(a);
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  // Reference latency from grant to done, straight from the access rules.
  function automatic int exp_lat(input bit we, input logic [3:0] be);
    if (!we) return 4;
    if (be == 4'b0000) return 2;
    return $countones(be) + 1;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we     = 1'b0;
    ref_mem[a] = d;
  endtask

  // Call right after driving a request at a negedge.
  task automatic wait_gnt(input int m, output int c);
    int n;
    n = 0;
    #1;
    while (!bus.o_gnt[m] && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bus.o_gnt[m]) c = cyc;
    else begin
      check("gnt_timeout", 0, 1);
      c = -1;
    end
  endtask

  task automatic wait_done(input int m, output int c);
    int n;
    n = 0;
    while (!bus.o_done[m] && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_done[m]) c = cyc;
    else begin
      check("done_timeout", 0, 1);
      c = -1;
    end
  endtask

  // One complete single-master transaction with all effects checked.
  task automatic run_txn(input string tag, input int m, input bit we,
                         input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be);
    int c0, c1, w0;
    logic [31:0] exp_rd;
    exp_rd = ref_word(a);
    @(negedge clk);
    bus.i_req      = 2'b00;
    bus.i_req[m]   = 1'b1;
    bus.i_we[m]    = we;
    bus.i_addr[m]  = a;
    bus.i_wdata[m] = wd;
    bus.i_be[m]    = be;
    wait_gnt(m, c0);
    if (c0 < 0) begin
      bus.i_req = 2'b00;
      return;
    end
    check({tag, "_gnt"}, bus.o_gnt, 2'b01 << m);
    w0 = wr_count;
    @(negedge clk);
    bus.i_req = 2'b00;
    wait_done(m, c1);
    if (c1 < 0) return;
    check({tag, "_lat"}, c1 - c0, exp_lat(we, be));
    if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) ref_mem[word_base(a) + AW'(k)] = wd[8*k +: 8];
      check({tag, "_nwr"}, wr_count - w0, $countones(be));
      check({tag, "_mem"}, mem_word(a), ref_word(a));
    end else begin
      check({tag, "_nwr"}, wr_count - w0, 0);
      check({tag, "_rdata"}, bus.o_rdata, exp_rd);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c0, c1, ng, n;
    bit saw;
    logic [1:0] seq [6];
    logic [31:0] old_w, new_w;

    bus.i_req = 2'b00;
    bus.i_we  = 2'b00;
    for (int m = 0; m < 2; m++) begin
      bus.i_addr[m]  = '0;
      bus.i_wdata[m] = '0;
      bus.i_be[m]    = '0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

    // Reset state.
    @(negedge clk);
    check("rst_done", bus.o_done, 2'b00);
    check("rst_rdata", bus.o_rdata, 32'h0);
    check("rst_we", ram_we, 1'b0);
    check("rst_raddr", ram_raddr, 10'h0);
    check("rst_raddr2", ram_raddr2, 10'h0);
    check("rst_waddr", ram_waddr, 10'h0);
    check("rst_gnt", bus.o_gnt, 2'b00);
    rst_n = 1'b1;

    // Directed reads, writes, boundaries.
    preload(10'h10, 8'h11);
    preload(10'h11, 8'h22);
    preload(10'h12, 8'h33);
    preload(10'h13, 8'h44);
    run_txn("rd10", 0, 1'b0, 10'h10, 32'h0, 4'h0);
    check("rd10_val", bus.o_rdata, 32'h44332211);
    run_txn("rd13", 1, 1'b0, 10'h13, 32'h0, 4'h0);
    check("rd13_val", bus.o_rdata, 32'h44332211);
    old_w = ref_word(10'h20);
    run_txn("wr0101", 0, 1'b1, 10'h20, 32'hAABBCCDD, 4'b0101);
    check("wr0101_word", mem_word(10'h20), {old_w[31:24], 8'hBB, old_w[15:8], 8'hDD});
    run_txn("wr0000", 1, 1'b1, 10'h24, 32'h12345678, 4'b0000);
    run_txn("wr1111", 0, 1'b1, 10'h3FC, 32'hCAFEF00D, 4'b1111);
    run_txn("rd3fd", 1, 1'b0, 10'h3FD, 32'h0, 4'h0);
    check("rd3fd_val", bus.o_rdata, 32'hCAFEF00D);

    // Randomized single-master traffic, biased into a small window for reuse.
    for (int t = 0; t < 120; t++) begin
      int m;
      bit we;
      logic [AW-1:0] a;
      m  = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 1023))
                                       : AW'(10'h3E0 + $urandom_range(0, 31));
      run_txn("rand", m, we, a, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a write, after the first byte has landed.
    run_txn("pre_rst_rd", 0, 1'b0, 10'h10, 32'h0, 4'h0);
    @(negedge clk);
    bus.i_req      = 2'b10;
    bus.i_we[1]    = 1'b1;
    bus.i_addr[1]  = 10'h30;
    bus.i_wdata[1] = 32'h01020304;
    bus.i_be[1]    = 4'hF;
    wait_gnt(1, c0);
    @(negedge clk);
    bus.i_req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_we", ram_we, 1'b0);
    check("mrst_done", bus.o_done, 2'b00);
    check("mrst_rdata", bus.o_rdata, 32'h0);
    check("mrst_byte0", mem[10'h30], 8'h04);
    check("mrst_byte1", mem[10'h31], ref_mem[10'h31]);
    ref_mem[10'h30] = 8'h04;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_done != 2'b00) saw = 1'b1;
    end
    check("mrst_no_done", saw, 1'b0);
    run_txn("post_rst_rd", 1, 1'b0, 10'h30, 32'h0, 4'h0);

    // Contention: both masters request continuously.
    do_reset();
    @(negedge clk);
    bus.i_we      = 2'b00;
    bus.i_addr[0] = 10'h40;
    bus.i_addr[1] = 10'h80;
    bus.i_req     = 2'b11;
    ng = 0;
    n  = 0;
    while (ng < 6 && n < 100) begin
      #1;
      if (bus.o_gnt != 2'b00) begin
        check("cont_onehot", 32'($countones(bus.o_gnt)), 1);
        seq[ng] = bus.o_gnt;
        ng++;
      end
      @(negedge clk);
      n++;
    end
    bus.i_req = 2'b00;
    check("cont_count", ng, 6);
    for (int i = 0; i < ng; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      check("cont_order", seq[i], 2'b01);
`else
      check("cont_order", seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    repeat (8) @(negedge clk);

    // Back-to-back: m1 reads a word, m0 writes it granted on m1's done cycle.
    old_w = ref_word(10'h50);
    new_w = 32'h5A6B7C8D;
    @(negedge clk);
    bus.i_req     = 2'b10;
    bus.i_we[1]   = 1'b0;
    bus.i_addr[1] = 10'h50;
    wait_gnt(1, c0);
    @(negedge clk);
    bus.i_req      = 2'b01;
    bus.i_we[0]    = 1'b1;
    bus.i_addr[0]  = 10'h50;
    bus.i_wdata[0] = new_w;
    bus.i_be[0]    = 4'hF;
    wait_done(1, c1);
    #1;
    check("b2b_rd_lat", c1 - c0, 4);
    check("b2b_rd_old", bus.o_rdata, old_w);
    check("b2b_gnt_same", bus.o_gnt, 2'b01);
    @(negedge clk);
    bus.i_req = 2'b00;
    wait_done(0, c0);
    check("b2b_wr_lat", c0 - c1, 5);
    for (int k = 0; k < 4; k++) ref_mem[10'h50 + k] = new_w[8*k +: 8];
    run_txn("b2b_rd_new", 1, 1'b0, 10'h50, 32'h0, 4'h0);
    check("b2b_new_val", bus.o_rdata, new_w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
